// File: rtl/mcpu_bus.sv
// Main-CPU memory/IO front end: address decode, banked ROM fetch through a
// one-entry cache over an SDRAM req/ack handshake, RAM selects and vblank IRQ.
module mcpu_bus #(
  parameter int          ROM_AW      = 18,
  parameter logic [15:0] BANK_REG    = 16'hF008,
  parameter int          IRQ_TIMEOUT = 2048
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [15:0]       mcpu_ab,
  input  logic [7:0]        mcpu_dout,
  input  logic              mcpu_rd,
  input  logic              mcpu_wr,
  input  logic              mcpu_io,
  input  logic              mcpu_m1,
  output logic [7:0]        mcpu_din,
  output logic              mcpu_wait,
  output logic              sirq_n,
  input  logic              vblank,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic              vram_cs,
  output logic              wram_cs,
  output logic              ram_we,
  input  logic [7:0]        vram_q,
  input  logic [7:0]        wram_q
);

  localparam int TW = $clog2(IRQ_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL} fetch_state_t;

  fetch_state_t      state_reg;
  logic              rom_req_reg;
  logic [ROM_AW-1:0] rom_addr_reg;
  logic              cache_valid_reg;
  logic [ROM_AW-1:0] cache_tag_reg;
  logic [7:0]        cache_data_reg;
  logic [2:0]        bank_reg;
  logic              wr_prev_reg;
  logic              vblank_prev_reg;
  logic              ack_prev_reg;
  logic              sirq_n_reg;
  logic [TW-1:0]     irq_timer_reg;

  logic              mem_access;
  logic              fixed_sel;
  logic              banked_sel;
  logic              rom_sel;
  logic              rom_rd;
  logic [ROM_AW-1:0] rom_addr_next;
  logic              cache_hit;
  logic              bank_we;
  logic              irq_ack;
  logic              vblank_rise;
  logic              unused_dout;

  assign mem_access = ~mcpu_io;
  assign fixed_sel  = mem_access & ~mcpu_ab[15];
  assign banked_sel = mem_access & (mcpu_ab[15:14] == 2'b10);
  assign rom_sel    = fixed_sel | banked_sel;
  assign rom_rd     = rom_sel & mcpu_rd;

  // Banked window: 16 KiB pages stacked after the 32 KiB fixed region.
  assign rom_addr_next = fixed_sel ? ROM_AW'(mcpu_ab[14:0])
                       : ROM_AW'(32'h0000_8000 + ({29'd0, bank_reg} << 14) + {18'd0, mcpu_ab[13:0]});

  assign cache_hit = cache_valid_reg & (cache_tag_reg == rom_addr_next);
  assign mcpu_wait = rom_rd & ~cache_hit;

  assign vram_cs = mem_access & (mcpu_ab[15:13] == 3'b110);
  assign wram_cs = mem_access & (mcpu_ab[15:13] == 3'b111) & (mcpu_ab[12:11] != 2'b11);
  assign ram_we  = mcpu_wr & (vram_cs | wram_cs);

  assign bank_we     = mcpu_wr & ~wr_prev_reg & mem_access & (mcpu_ab == BANK_REG);
  assign irq_ack     = mcpu_io & mcpu_m1;
  assign vblank_rise = vblank & ~vblank_prev_reg;
  assign unused_dout = &{1'b0, mcpu_dout[7:3]};

  assign rom_req  = rom_req_reg;
  assign rom_addr = rom_addr_reg;
  assign sirq_n   = sirq_n_reg;

  always_comb begin
    mcpu_din = 8'hFF;
    if (rom_sel)      mcpu_din = cache_data_reg;
    else if (vram_cs) mcpu_din = vram_q;
    else if (wram_cs) mcpu_din = wram_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      rom_req_reg     <= 1'b0;
      rom_addr_reg    <= '0;
      cache_valid_reg <= 1'b0;
      cache_tag_reg   <= '0;
      cache_data_reg  <= 8'h00;
      bank_reg        <= 3'd0;
      wr_prev_reg     <= 1'b0;
    end else begin
      wr_prev_reg <= mcpu_wr;
      case (state_reg)
        ST_IDLE: begin
          if (rom_rd && !cache_hit) begin
            state_reg    <= ST_REQ;
            rom_req_reg  <= 1'b1;
            rom_addr_reg <= rom_addr_next;
          end
        end
        ST_REQ: begin
          if (rom_ack) begin
            state_reg       <= ST_FILL;
            rom_req_reg     <= 1'b0;
            cache_tag_reg   <= rom_addr_reg;
            cache_data_reg  <= rom_data;
            cache_valid_reg <= 1'b1;
          end
        end
        ST_FILL: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
      // A bank switch makes any cached banked byte stale.
      if (bank_we) begin
        bank_reg        <= mcpu_dout[2:0];
        cache_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_prev_reg <= 1'b0;
      ack_prev_reg    <= 1'b0;
      sirq_n_reg      <= 1'b1;
      irq_timer_reg   <= '0;
    end else begin
      vblank_prev_reg <= vblank;
      ack_prev_reg    <= irq_ack;
      if (sirq_n_reg) begin
        if (vblank_rise) begin
          sirq_n_reg    <= 1'b0;
          irq_timer_reg <= '0;
        end
      end else if (ack_prev_reg && !irq_ack) begin
        sirq_n_reg <= 1'b1;
      end else if (!irq_ack && irq_timer_reg == TW'(IRQ_TIMEOUT - 1)) begin
        sirq_n_reg <= 1'b1;
      end else begin
        irq_timer_reg <= irq_timer_reg + TW'(1);
      end
    end
  end

endmodule
